// File: rtl/mix_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mix_mem_pkg
//  Description : Shared sizes and client indices for the core memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
package mix_mem_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 31;
  localparam int NCLI     = 3;

  localparam int CLI_IN   = 0;
  localparam int CLI_OUT  = 1;
  localparam int CLI_SRAM = 2;

  // Wait counters must hold STARVE values up to 255.
  localparam int CNT_W    = 8;

  // Width of an index into n entries; never less than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational first-requester search starting at a given
//                index and wrapping from N-1 back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import mix_mem_pkg::*;
#(
  parameter int N  = NCLI,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Walk the request vector from start upward and keep the first hit.
  always_comb begin
    int j;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!any && req[j]) begin
        idx = PW'(j);
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single core memory port between the CPU (fixed
//                priority) and the I/O clients (round-robin in idle CPU
//                cycles), with a starvation counter that can steal one cycle
//                from the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mix_mem_pkg::*;
#(
  parameter int ADDR_W = mix_mem_pkg::ADDR_W,
  parameter int DATA_W = mix_mem_pkg::DATA_W,
  parameter int NCLI   = mix_mem_pkg::NCLI,
  parameter int STARVE = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic                     cpu_stall,
  output logic                     cpu_rvalid,
  input  logic [NCLI-1:0]          io_req,
  input  logic [NCLI-1:0]          io_we,
  input  logic [NCLI*ADDR_W-1:0]   io_addr,
  input  logic [NCLI*DATA_W-1:0]   io_wdata,
  output logic [NCLI-1:0]          io_gnt,
  output logic [NCLI-1:0]          io_rvalid,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int c_PTR_W = ptr_w(NCLI);

  logic [c_PTR_W-1:0]            r_rr_ptr;
  logic [NCLI-1:0][CNT_W-1:0]    r_cnt;
  logic                          r_urgent_blk;
  logic                          r_tag_cpu;
  logic [NCLI-1:0]               r_tag_io;

  logic [NCLI-1:0]               w_sat;
  logic [NCLI-1:0]               w_urg_req;
  logic [c_PTR_W-1:0]            w_urg_idx;
  logic                          w_urg_any;
  logic [c_PTR_W-1:0]            w_rr_idx;
  logic                          w_rr_any;
  logic                          w_cpu_win;
  logic                          w_cli_win;
  logic                          w_urgent;
  logic [c_PTR_W-1:0]            w_cli_idx;
  logic [NCLI-1:0]               w_gnt;

  // Read data goes straight from memory to the clients; only ownership
  // (rvalid) is produced here.
  logic                          w_unused;
  assign w_unused = ^mem_rdata;

  // A client is urgent once its wait counter has saturated, unless an urgent
  // grant happened last cycle (that cycle belongs to the CPU).
  always_comb begin
    for (int i = 0; i < NCLI; i++) begin
      w_sat[i] = (r_cnt[i] == CNT_W'(STARVE));
    end
    w_urg_req = io_req & w_sat & {NCLI{~r_urgent_blk}};
  end

  rr_pick #(.N(NCLI), .PW(c_PTR_W)) u_urg_pick (
    .req   (w_urg_req),
    .start ('0),
    .idx   (w_urg_idx),
    .any   (w_urg_any)
  );

  rr_pick #(.N(NCLI), .PW(c_PTR_W)) u_rr_pick (
    .req   (io_req),
    .start (r_rr_ptr),
    .idx   (w_rr_idx),
    .any   (w_rr_any)
  );

  // Winner selection: urgent client, then CPU, then round-robin client.
  // Everything is held off while reset is low.
  always_comb begin
    w_cpu_win = 1'b0;
    w_cli_win = 1'b0;
    w_urgent  = 1'b0;
    w_cli_idx = '0;
    cpu_stall = 1'b0;
    if (reset) begin
      if (w_urg_any) begin
        w_cli_win = 1'b1;
        w_urgent  = 1'b1;
        w_cli_idx = w_urg_idx;
        cpu_stall = cpu_req;
      end else if (cpu_req) begin
        w_cpu_win = 1'b1;
      end else if (w_rr_any) begin
        w_cli_win = 1'b1;
        w_cli_idx = w_rr_idx;
      end
    end
    w_gnt = w_cli_win ? (NCLI'(1) << w_cli_idx) : '0;
  end

  assign io_gnt = w_gnt;

  // Memory port mux; an idle cycle presents the CPU address with no write.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (w_cpu_win) begin
      mem_we    = cpu_we;
    end else if (w_cli_win) begin
      mem_addr  = io_addr[w_cli_idx*ADDR_W +: ADDR_W];
      mem_wdata = io_wdata[w_cli_idx*DATA_W +: DATA_W];
      mem_we    = io_we[w_cli_idx];
    end
  end

  // Pointer, wait counters, urgent block and read-ownership tags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr     <= '0;
      r_cnt        <= '0;
      r_urgent_blk <= 1'b0;
      r_tag_cpu    <= 1'b0;
      r_tag_io     <= '0;
    end else begin
      if (w_cli_win) begin
        r_rr_ptr <= (w_cli_idx == c_PTR_W'(NCLI-1)) ? '0 : w_cli_idx + 1'b1;
      end
      for (int i = 0; i < NCLI; i++) begin
        if (!io_req[i] || w_gnt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != CNT_W'(STARVE)) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_urgent_blk <= w_urgent;
      r_tag_cpu    <= w_cpu_win & ~cpu_we;
      r_tag_io     <= w_gnt & ~io_we;
    end
  end

  assign cpu_rvalid = r_tag_cpu & reset;
  assign io_rvalid  = r_tag_io & {NCLI{reset}};

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter. Directed stimulus
//                pushes expected grants and read returns (cycle-stamped);
//                a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 31;
  localparam int NC  = 3;
  localparam int CPU = 3;

  logic               clk;
  logic               reset;
  logic               cpu_req, cpu_we;
  logic [AW-1:0]      cpu_addr;
  logic [DW-1:0]      cpu_wdata;
  logic               cpu_stall, cpu_rvalid;
  logic [NC-1:0]      io_req, io_we, io_gnt, io_rvalid;
  logic [NC*AW-1:0]   io_addr;
  logic [NC*DW-1:0]   io_wdata;
  logic [AW-1:0]      mem_addr;
  logic               mem_we;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NCLI(NC), .STARVE(15)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory, preloaded on the first clock edge.
  logic [DW-1:0] mem [4096];
  bit            mem_loaded;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      mem[12'h123] <= 31'h1ABCDEF1;
      mem[12'h200] <= 31'h11111111;
      mem[12'h201] <= 31'h22222222;
      mem[12'h202] <= 31'h33333333;
      mem[12'h203] <= 31'h44444444;
      mem_loaded   <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct { int cyc; int who; bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } gnt_t;
  typedef struct { int cyc; int who; logic [DW-1:0] data; } rd_t;
  gnt_t q_gnt[$];
  rd_t  q_rd[$];

  int  compared   = 0;
  int  mismatched = 0;
  bit  done       = 0;
  bit  prev_stall = 0;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic exp_gnt(input int who, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    gnt_t e;
    e.cyc = cyc; e.who = who; e.we = we; e.addr = a; e.data = d;
    q_gnt.push_back(e);
  endtask

  task automatic exp_rd(input int who, input logic [DW-1:0] d);
    rd_t e;
    e.cyc = cyc + 1; e.who = who; e.data = d;
    q_rd.push_back(e);
  endtask

  task automatic set_cli(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    io_req[i] = 1'b1;
    io_we[i]  = we;
    io_addr[i*AW +: AW]  = a;
    io_wdata[i*DW +: DW] = d;
  endtask

  task automatic cpu_rd(input logic [AW-1:0] a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
  endtask

  // One CPU read cycle of 0x123 with its grant and data return.
  task automatic cpu_load_cycle();
    exp_gnt(CPU, 1'b0, 12'h123, '0);
    exp_rd(CPU, 31'h1ABCDEF1);
    tick();
  endtask

  // ---------------- monitor helpers ----------------
  task automatic flush(input bit all);
    gnt_t g;
    rd_t  r;
    while (q_gnt.size() > 0 && (all || q_gnt[0].cyc < cyc)) begin
      g = q_gnt.pop_front();
      compared++; mismatched++;
      $display("FAIL grant_missing: cycle %0d who %0d required, not seen", g.cyc, g.who);
    end
    while (q_rd.size() > 0 && (all || q_rd[0].cyc < cyc)) begin
      r = q_rd.pop_front();
      compared++; mismatched++;
      $display("FAIL rvalid_missing: cycle %0d who %0d data %h required, not seen", r.cyc, r.who, r.data);
    end
  endtask

  task automatic chk_gnt(input int who, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    gnt_t e;
    compared++;
    if (q_gnt.size() == 0 || q_gnt[0].cyc != cyc) begin
      mismatched++;
      $display("FAIL grant_unexpected: cycle %0d got who %0d we %0b addr %h, required no grant", cyc, who, we, a);
    end else begin
      e = q_gnt.pop_front();
      if (who != e.who || we != e.we || a !== e.addr || (e.we && d !== e.data)) begin
        mismatched++;
        $display("FAIL grant: cycle %0d got who %0d we %0b addr %h data %h, required who %0d we %0b addr %h data %h",
                 cyc, who, we, a, d, e.who, e.we, e.addr, e.data);
      end
    end
  endtask

  task automatic chk_rd(input int who, input logic [DW-1:0] d);
    rd_t e;
    compared++;
    if (q_rd.size() == 0 || q_rd[0].cyc != cyc) begin
      mismatched++;
      $display("FAIL rvalid_unexpected: cycle %0d got who %0d data %h, required none", cyc, who, d);
    end else begin
      e = q_rd.pop_front();
      if (who != e.who || d !== e.data) begin
        mismatched++;
        $display("FAIL rvalid: cycle %0d got who %0d data %h, required who %0d data %h",
                 cyc, who, d, e.who, e.data);
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int who;
    forever begin
      @(negedge clk);
      if (done) begin
        flush(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
      end
      flush(1'b0);
      if (!reset) begin
        compared++;
        if (mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
          mismatched++;
          $display("FAIL reset_gating: cycle %0d mem_we %b cpu_stall %b, required 0 0", cyc, mem_we, cpu_stall);
        end
      end
      compared++;
      if (cpu_stall && (!cpu_req || prev_stall)) begin
        mismatched++;
        $display("FAIL stall_rule: cycle %0d cpu_stall 1 with cpu_req %b prev_stall %b, required 0", cyc, cpu_req, prev_stall);
      end
      prev_stall = cpu_stall;
      if (io_gnt != '0) begin
        who = -2;
        for (int i = 0; i < NC; i++) if (io_gnt == (NC'(1) << i)) who = i;
        chk_gnt(who, mem_we, mem_addr, mem_wdata);
      end
      if (reset && cpu_req && !cpu_stall) chk_gnt(CPU, mem_we, mem_addr, mem_wdata);
      if (cpu_rvalid) chk_rd(CPU, mem_rdata);
      if (io_rvalid != '0) begin
        who = -2;
        for (int i = 0; i < NC; i++) if (io_rvalid == (NC'(1) << i)) who = i;
        chk_rd(who, mem_rdata);
      end
    end
  end

  // Bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    io_req = '0; io_we = '0; io_addr = '0; io_wdata = '0;
    tick(); tick();

    // Reset held with every requester active: nothing granted, no rvalid.
    cpu_rd(12'h123);
    set_cli(0, 1'b0, 12'h200, '0);
    set_cli(1, 1'b0, 12'h201, '0);
    set_cli(2, 1'b1, 12'h202, 31'h7654321);
    repeat (3) tick();

    // Release: CPU wins the first cycle.
    reset = 1'b1;
    exp_gnt(CPU, 1'b0, 12'h123, '0); exp_rd(CPU, 31'h1ABCDEF1);
    tick();

    // CPU write then read-back of the same address.
    io_req = '0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h050; cpu_wdata = 31'h0AAAAAAA;
    exp_gnt(CPU, 1'b1, 12'h050, 31'h0AAAAAAA);
    tick();
    cpu_rd(12'h050);
    exp_gnt(CPU, 1'b0, 12'h050, '0); exp_rd(CPU, 31'h0AAAAAAA);
    tick();
    cpu_req = 1'b0;
    tick();

    // Round-robin from pointer 0: order 0,1,2.
    set_cli(0, 1'b0, 12'h200, '0);
    set_cli(1, 1'b0, 12'h201, '0);
    set_cli(2, 1'b0, 12'h202, '0);
    exp_gnt(0, 1'b0, 12'h200, '0); exp_rd(0, 31'h11111111); tick();
    io_req[0] = 1'b0;
    exp_gnt(1, 1'b0, 12'h201, '0); exp_rd(1, 31'h22222222); tick();
    io_req[1] = 1'b0;
    exp_gnt(2, 1'b0, 12'h202, '0); exp_rd(2, 31'h33333333); tick();
    io_req = '0;
    // Single grant to client 0 moves the pointer to 1.
    set_cli(0, 1'b0, 12'h203, '0);
    exp_gnt(0, 1'b0, 12'h203, '0); exp_rd(0, 31'h44444444); tick();
    // All three request writes: order 1,2,0.
    set_cli(0, 1'b1, 12'h300, 31'h00000A0A);
    set_cli(1, 1'b1, 12'h301, 31'h00000B0B);
    set_cli(2, 1'b1, 12'h302, 31'h00000C0C);
    exp_gnt(1, 1'b1, 12'h301, 31'h00000B0B); tick();
    io_req[1] = 1'b0;
    exp_gnt(2, 1'b1, 12'h302, 31'h00000C0C); tick();
    io_req[2] = 1'b0;
    exp_gnt(0, 1'b1, 12'h300, 31'h00000A0A); tick();
    io_req = '0;
    cpu_rd(12'h301);
    exp_gnt(CPU, 1'b0, 12'h301, '0); exp_rd(CPU, 31'h00000B0B); tick();

    // Starvation: client 2 write under continuous CPU load.
    set_cli(2, 1'b1, 12'h010, 31'h7FFFFFFF);
    cpu_rd(12'h123);
    repeat (15) cpu_load_cycle();
    exp_gnt(2, 1'b1, 12'h010, 31'h7FFFFFFF); tick();
    io_req[2] = 1'b0;
    cpu_load_cycle();
    cpu_rd(12'h010);
    exp_gnt(CPU, 1'b0, 12'h010, '0); exp_rd(CPU, 31'h7FFFFFFF); tick();
    cpu_req = 1'b0;
    tick();

    // Dual urgent: clients 0 and 1 starve together.
    set_cli(0, 1'b0, 12'h200, '0);
    set_cli(1, 1'b1, 12'h020, 31'h15555555);
    cpu_rd(12'h123);
    repeat (15) cpu_load_cycle();
    exp_gnt(0, 1'b0, 12'h200, '0); exp_rd(0, 31'h11111111); tick();
    io_req[0] = 1'b0;
    cpu_load_cycle();
    exp_gnt(1, 1'b1, 12'h020, 31'h15555555); tick();
    io_req[1] = 1'b0;
    cpu_load_cycle();
    cpu_rd(12'h020);
    exp_gnt(CPU, 1'b0, 12'h020, '0); exp_rd(CPU, 31'h15555555); tick();
    cpu_req = 1'b0;
    tick();

    // Reset mid-read, with a partly aged counter on client 2.
    set_cli(2, 1'b1, 12'h030, 31'h00000030);
    exp_gnt(2, 1'b1, 12'h030, 31'h00000030); tick();
    set_cli(2, 1'b1, 12'h031, 31'h00000031);
    cpu_rd(12'h123);
    repeat (5) cpu_load_cycle();
    cpu_req = 1'b0;
    set_cli(1, 1'b0, 12'h201, '0);
    exp_gnt(1, 1'b0, 12'h201, '0); tick();
    reset = 1'b0;
    io_req[1] = 1'b0;
    cpu_rd(12'h123);
    tick(); tick();
    // After release client 2 must wait the full 15 cycles again.
    reset = 1'b1;
    repeat (15) cpu_load_cycle();
    exp_gnt(2, 1'b1, 12'h031, 31'h00000031); tick();
    io_req = '0;
    cpu_load_cycle();
    cpu_req = 1'b0;
    tick(); tick();
    done = 1'b1;
  end

endmodule
`default_nettype wire
